// File: rtl/chip8_clk_pkg.sv
// Shared types and constants for the CHIP-8 clock-control stage.
// The top module's header describes the CHIP8_LOCK_WATCH_EN build option.
package chip8_clk_pkg;

  typedef enum logic [1:0] {
    StWaitLock,
    StHold,
    StRun
  } clk_state_e;

  localparam int unsigned DefClkHz  = 1000000;
  localparam int unsigned DefTickHz = 60;

  // The accumulator must hold acc + rate, with acc < clk_hz and rate < clk_hz.
  function automatic int unsigned acc_width(input int unsigned clk_hz);
    return $clog2(2 * clk_hz);
  endfunction

endpackage

// File: rtl/chip8_clk_ctrl_if.sv
// Bundle of lock, rate-control and timebase signals between the clock stage and the CHIP-8 core.
// The master side is the clock controller; the slave side is its consumer.
interface chip8_clk_ctrl_if #(
  parameter int unsigned RATE_W = 12
) ();

  logic              pll_locked;
  logic              pause;
  logic [RATE_W-1:0] cpu_rate;
  logic              sys_rst;
  logic              tick_60;
  logic              cpu_en;
  logic              running;

  modport master (
    input  pll_locked,
    input  pause,
    input  cpu_rate,
    output sys_rst,
    output tick_60,
    output cpu_en,
    output running
  );

  modport slave (
    output pll_locked,
    output pause,
    output cpu_rate,
    input  sys_rst,
    input  tick_60,
    input  cpu_en,
    input  running
  );

endinterface

// File: rtl/chip8_rate_acc.sv
// Fractional rate accumulator: emits exactly `rate` single-cycle pulses per CLK_HZ enabled cycles
// with no long-term drift.
module chip8_rate_acc
  import chip8_clk_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefClkHz,
  parameter int unsigned RATE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              pulse
);

  localparam int unsigned    AccW  = acc_width(CLK_HZ);
  localparam logic [AccW-1:0] Limit = AccW'(CLK_HZ);

  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] sum;
  logic            pulse_d;

  always_comb begin
    sum     = acc_q + AccW'(rate);
    acc_d   = acc_q;
    pulse_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= Limit) begin
        acc_d   = sum - Limit;
        pulse_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    // A disabled cycle (pause) simply holds acc, so a pending overflow recurs after it.
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      pulse <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pulse <= pulse_d;
    end
  end

endmodule

// File: rtl/chip8_clk_ctrl.sv
// PLL-lock reset stretcher plus 60 Hz timer tick and programmable CPU enable for the CHIP-8 core.
// Define CHIP8_LOCK_WATCH_EN to drop back to reset when lock is lost while running.
module chip8_clk_ctrl
  import chip8_clk_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DefClkHz,
  parameter int unsigned TICK_HZ  = DefTickHz,
  parameter int unsigned RST_HOLD = 256,
  parameter int unsigned RATE_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  chip8_clk_ctrl_if.master    bus
);

  localparam int unsigned      HoldW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam int unsigned      TickW    = $clog2(TICK_HZ + 1);
  localparam logic [TickW-1:0] TickRate = TickW'(TICK_HZ);

  clk_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sync_q, locked_s;
  logic             sys_rst_q, running_q;
  logic             acc_clr, acc_en;
  logic             tick_pulse, cpu_pulse;

  // pll_locked comes from another timing domain; two flops before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= bus.pll_locked;
      locked_s <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StWaitLock: begin
        hold_d = '0;
        if (locked_s) state_d = StHold;
      end
      StHold: begin
        hold_d = hold_q + 1'b1;
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (hold_q == HoldLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
`ifdef CHIP8_LOCK_WATCH_EN
        if (!locked_s) state_d = StWaitLock;
`endif
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StWaitLock;
      hold_q    <= '0;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sys_rst_q <= (state_d != StRun);
      running_q <= (state_d == StRun);
    end
  end

  // Accumulate only in cycles that are RUN now and stay RUN; the leaving edge clears.
  always_comb begin
    acc_clr = (state_q != StRun) || (state_d != StRun);
    acc_en  = !bus.pause;
  end

  chip8_rate_acc #(
    .CLK_HZ (CLK_HZ),
    .RATE_W (TickW)
  ) u_tick_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .rate  (TickRate),
    .pulse (tick_pulse)
  );

  chip8_rate_acc #(
    .CLK_HZ (CLK_HZ),
    .RATE_W (RATE_W)
  ) u_cpu_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .rate  (bus.cpu_rate),
    .pulse (cpu_pulse)
  );

  assign bus.sys_rst = sys_rst_q;
  assign bus.running = running_q;
  assign bus.tick_60 = tick_pulse;
  assign bus.cpu_en  = cpu_pulse;

endmodule

// File: tb/tb_chip8_clk_ctrl.sv
// Directed bench for chip8_clk_ctrl with a scaled-down clock (1 kHz) so full rate periods stay short.
// Honours CHIP8_LOCK_WATCH_EN for the lock-loss-in-RUN expectations.
module tb_chip8_clk_ctrl;

  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned TickHz  = 60;
  localparam int unsigned RstHold = 4;
  localparam int unsigned RateW   = 8;

  logic clk = 1'b0;
  logic rst;

  chip8_clk_ctrl_if #(.RATE_W(RateW)) bus ();

  chip8_clk_ctrl #(
    .CLK_HZ   (ClkHz),
    .TICK_HZ  (TickHz),
    .RST_HOLD (RstHold),
    .RATE_W   (RateW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, n_tick, n_cpu, first_tick, first_cpu, last_tick, min_gap, max_gap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc        = 0;
    n_tick     = 0;
    n_cpu      = 0;
    first_tick = 0;
    first_cpu  = 0;
    last_tick  = 0;
    min_gap    = 1 << 30;
    max_gap    = 0;
  endtask

  // Sample on the falling edge; cycle i's pulse shows up after the rising edge closing cycle i.
  task automatic run(input int n);
    int gap;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (bus.tick_60 === 1'b1) begin
        n_tick++;
        if (first_tick == 0) begin
          first_tick = cyc;
        end else begin
          gap = cyc - last_tick;
          if (gap < min_gap) min_gap = gap;
          if (gap > max_gap) max_gap = gap;
        end
        last_tick = cyc;
      end
      if (bus.cpu_en === 1'b1) begin
        n_cpu++;
        if (first_cpu == 0) first_cpu = cyc;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    bus.pause      = 1'b0;
    bus.cpu_rate   = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_sys_rst", bus.sys_rst, 1);
    check_eq("reset_running", bus.running, 0);
    check_eq("reset_tick", bus.tick_60, 0);
    check_eq("reset_cpu_en", bus.cpu_en, 0);

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_lock_sys_rst", bus.sys_rst, 1);

    // Lock, glitch low during HOLD, relock: release comes 6 edges after the relock sample (edge 5).
    bus.pll_locked = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      if (e == 2) bus.pll_locked = 1'b0;
      if (e == 4) bus.pll_locked = 1'b1;
      if (e == 6) check_eq("glitch_no_release_e6", bus.sys_rst, 1);
      if (e == 10) check_eq("glitch_no_release_e10", bus.sys_rst, 1);
      if (e == 11) begin
        check_eq("relock_sys_rst_e11", bus.sys_rst, 0);
        check_eq("relock_running_e11", bus.running, 1);
      end
    end

    // Asynchronous reset mid-cycle while running.
    bus.cpu_rate = 8'd50;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_sys_rst", bus.sys_rst, 1);
    check_eq("async_rst_running", bus.running, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) check_eq("lock_sys_rst_e5", bus.sys_rst, 1);
      if (e == 6) begin
        check_eq("lock_sys_rst_e6", bus.sys_rst, 0);
        check_eq("lock_running_e6", bus.running, 1);
      end
    end

    // One full period: 60*17 >= 1000 first, 50*20 = 1000 first.
    clear_stats();
    run(1000);
    check_eq("first_tick_cycle", first_tick, 17);
    check_eq("first_cpu_cycle", first_cpu, 20);
    check_eq("ticks_per_period", n_tick, 60);
    check_eq("cpu_per_period_50", n_cpu, 50);
    check_eq("tick_min_gap", min_gap, 16);
    check_eq("tick_max_gap", max_gap, 17);

    // Rate 50 for 10 cycles leaves cpu acc at 500; rate 0 holds it; rate 100 then fires on cycle 5.
    clear_stats();
    run(10);
    check_eq("rate50_short_no_cpu", n_cpu, 0);
    bus.cpu_rate = 8'd0;
    clear_stats();
    run(100);
    check_eq("rate0_no_cpu", n_cpu, 0);
    bus.cpu_rate = 8'd100;
    clear_stats();
    run(1000);
    check_eq("rate100_first_cpu", first_cpu, 5);
    check_eq("cpu_per_period_100", n_cpu, 100);

    // Tick acc is now 60*1110 mod 1000 = 600 (7 cycles to go); cpu acc is 500 (5 to go).
    bus.pause = 1'b1;
    clear_stats();
    run(50);
    check_eq("pause_no_tick", n_tick, 0);
    check_eq("pause_no_cpu", n_cpu, 0);
    bus.pause = 1'b0;
    clear_stats();
    run(20);
    check_eq("post_pause_tick", first_tick, 7);
    check_eq("post_pause_cpu", first_cpu, 5);

    // Lock loss while running.
    bus.pll_locked = 1'b0;
`ifdef CHIP8_LOCK_WATCH_EN
    @(negedge clk);
    @(negedge clk);
    check_eq("drop_sys_rst_e1", bus.sys_rst, 0);
    @(negedge clk);
    check_eq("drop_sys_rst_e2", bus.sys_rst, 1);
    check_eq("drop_running_e2", bus.running, 0);
    clear_stats();
    run(1000);
    check_eq("drop_no_tick", n_tick, 0);
    check_eq("drop_no_cpu", n_cpu, 0);
`else
    clear_stats();
    run(1000);
    check_eq("drop_ignored_sys_rst", bus.sys_rst, 0);
    check_eq("drop_ignored_running", bus.running, 1);
    check_eq("drop_ignored_ticks", n_tick, 60);
    check_eq("drop_ignored_cpu", n_cpu, 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_clk_ctrl.md
# chip8_clk_ctrl

Clock-domain control stage directly downstream of the system PLL, running on the PLL's 1 MHz output. It turns the PLL lock indication into a clean, stretched system reset and derives the two CHIP-8 timebases from the single clock: the 60 Hz delay/sound timer tick and the programmable-rate CPU instruction enable. All CHIP-8 core logic consumes these single-cycle enables rather than separate clocks.

## Interface
Parameters:
- CLK_HZ, 1000000: input clock frequency in Hz; must exceed 2^RATE_W-1.
- TICK_HZ, 60: timer tick rate in Hz.
- RST_HOLD, 256: RUN-entry delay after lock, in clk cycles (>=1).
- RATE_W, 12: width of cpu_rate.

Ports:
- clk  in  1  1 MHz PLL output clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk.
- pause  in  1  freezes both timebases while high.
- cpu_rate  in  RATE_W  CPU instructions per second; 0 = CPU stopped.
- sys_rst  out  1  registered reset to the CHIP-8 core; high until RUN.
- tick_60  out  1  one-cycle timer-tick pulse.
- cpu_en  out  1  one-cycle instruction-enable pulse.
- running  out  1  high while state is RUN.

## Operation
- Reset values: state WAIT_LOCK, sys_rst=1, tick_60=0, cpu_en=0, running=0, both accumulators 0, hold counter 0, sync flops 0.
- pll_locked passes through a 2-flop synchroniser -> locked_s.
- States:
  - WAIT_LOCK: locked_s=1 -> HOLD, hold counter cleared.
  - HOLD: counter increments each cycle; locked_s=0 -> WAIT_LOCK; counter==RST_HOLD-1 -> RUN.
  - RUN: accumulators active; lock loss handling per Configuration.
- Outputs registered from next-state: sys_rst <= (next!=RUN), running <= (next==RUN).
- Rate accumulator (tick and CPU, identical): each RUN cycle with pause=0, sum = acc + rate; if sum >= CLK_HZ then acc <= sum-CLK_HZ and pulse <= 1, else acc <= sum and pulse <= 0. Width ceil(log2(2*CLK_HZ)) bits, no overflow. Exactly `rate` pulses per CLK_HZ cycles, no drift.
- tick uses rate=TICK_HZ; CPU uses cpu_rate sampled every cycle. Rate change takes effect on the next accumulation; acc is not cleared. cpu_rate=0: acc holds, no cpu_en.
- pause=1: both accumulators hold, both pulses 0; pause beats a simultaneous overflow (pulse lost to the freeze, not deferred-lost: acc unchanged, overflow recurs after pause drops).
- Leaving RUN or any non-RUN state: accumulators cleared, pulses 0.
- tick_60 and cpu_en are independent and may coincide.

## Timing
- sys_rst falls on edge RST_HOLD+2, counting the edge that first samples pll_locked=1 as edge 0 (2 sync + 1 transition + RST_HOLD-1 count).
- Default params: first tick_60 at the 16667th RUN cycle's following edge; subsequent spacing 16666 or 16667 cycles; 60 pulses per 1,000,000 cycles.
- Pulse latency: one edge after the accumulation cycle that overflows.
- rst asynchronous assert; all outputs to reset values immediately.

## Configuration
- CHIP8_LOCK_WATCH_EN defined: locked_s=0 in RUN -> WAIT_LOCK; sys_rst=1 and running=0 on the next edge, accumulators cleared.
- Not defined: once in RUN, locked_s is ignored until rst; only HOLD reacts to lock loss.

## Structure
- Package chip8_clk_pkg: state enum (WAIT_LOCK, HOLD, RUN), default CLK_HZ/TICK_HZ constants, accumulator-width function.
- Sub-module chip8_rate_acc (clk, rst, clr, en, rate, pulse), instantiated twice.

## Test plan
- rst release, pll_locked=1 from start, RST_HOLD=4 -> sys_rst low exactly on edge 6 after first sample; running rises same edge.
- pll_locked toggles low in HOLD cycle 2 -> back to WAIT_LOCK, sys_rst stays 1, counter restarts on relock.
- Run 1,000,000 cycles, cpu_rate=500 -> exactly 60 tick_60 and 500 cpu_en; tick spacing only 16666/16667.
- cpu_rate 500 -> 0 -> 1000 mid-run -> no cpu_en while 0; accumulator retained; 1000 pulses per following 1e6 cycles.
- pause high 50,000 cycles spanning an overflow -> zero pulses during pause; next tick exactly remaining-count cycles after release.
- Lock drop in RUN: with CHIP8_LOCK_WATCH_EN -> sys_rst=1 two edges after sync, pulses stop; without -> no change in sys_rst or pulse counts.
